// File: rtl/poly_s_pack_if.sv
`default_nettype none
// ============================================================================
// Module   : poly_s_pack_if
// Purpose  : Groups the coefficient stream coming in from the secret-coefficient
//            sampler and the packed-word valid/ready stream going out to the
//            sk assembly buffer.
// Signals  : i_coeff_valid / i_coeff_data  - coefficient strobe and encoded value
//            o_word_valid / o_word_data    - packed output word and its valid
//            i_word_ready                  - consumer accept
// Modports : slave  - the packer (consumes coefficients, produces words)
//            master - the environment driving coefficients and accepting words
// Revision : 1.0 - initial release
// ============================================================================
interface poly_s_pack_if #(
   parameter int WORD_W = 32
);
   logic              i_coeff_valid;
   logic [3:0]        i_coeff_data;
   logic              o_word_valid;
   logic [WORD_W-1:0] o_word_data;
   logic              i_word_ready;

   modport slave (
      input  i_coeff_valid,
      input  i_coeff_data,
      input  i_word_ready,
      output o_word_valid,
      output o_word_data
   );

   modport master (
      output i_coeff_valid,
      output i_coeff_data,
      output i_word_ready,
      input  o_word_valid,
      input  o_word_data
   );
endinterface
`default_nettype wire

// File: rtl/poly_s_pack.sv
`default_nettype none
// ============================================================================
// Module   : poly_s_pack
// Purpose  : Streaming bit-packer for secret polynomials s1/s2. Packs each
//            coefficient (encoded eta - s) LSB-first into a 3-bit (eta=2) or
//            4-bit (eta=4) field and emits 32-bit words on valid/ready.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            i_start            - begin one polynomial (IDLE/DONE only)
//            i_security_level   - 2, 3 or 5; latched at i_start
//            bus (slave)        - coefficient stream in, word stream out
//            o_busy             - high in RUN and FLUSH
//            o_done             - high in DONE until next start or reset
//            o_err              - sticky error flag
// Revision : 1.0 - initial release
// ============================================================================
module poly_s_pack #(
   parameter int COEFF_NUM = 256,
   parameter int WORD_W    = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [2:0]  i_security_level,
   poly_s_pack_if.slave bus,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);
   localparam int              c_ACC_W  = 2 * WORD_W;
   localparam int              c_CNT_W  = $clog2(COEFF_NUM + 1);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(COEFF_NUM - 1);
   localparam logic [6:0]      c_WORD   = 7'(WORD_W);
   localparam logic [7:0]      c_CAP    = 8'(c_ACC_W);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_RUN   = 2'd1;
   localparam logic [1:0] c_FLUSH = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic               r_w4;          // 1: 4-bit fields (eta=4)
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_ACC_W-1:0] r_acc;
   logic [6:0]         r_acc_cnt;
   logic               r_out_valid;
   logic [WORD_W-1:0]  r_out_data;
   logic               r_err;

   logic               w_start;
   logic               w_accept;
   logic               w_out_free;
   logic               w_load;
   logic [c_ACC_W-1:0] w_acc_sh;
   logic [6:0]         w_cnt_sh;
   logic [6:0]         w_fw;
   logic [3:0]         w_field;
   logic               w_range_err;
   logic               w_ovf;
   logic               w_append;
   logic [c_ACC_W-1:0] w_ins;
   logic               w_err_set;

   assign w_start    = i_start && (r_state == c_IDLE || r_state == c_DONE);
   assign w_accept   = bus.i_coeff_valid && (r_state == c_RUN);
   assign w_out_free = !r_out_valid || bus.i_word_ready;
   assign w_load     = (r_acc_cnt >= c_WORD) && w_out_free;

   // Shift out the loaded word first so the new field lands after it.
   assign w_acc_sh   = w_load ? (r_acc >> WORD_W) : r_acc;
   assign w_cnt_sh   = w_load ? (r_acc_cnt - c_WORD) : r_acc_cnt;

   assign w_fw        = r_w4 ? 7'd4 : 7'd3;
   assign w_field     = r_w4 ? bus.i_coeff_data : {1'b0, bus.i_coeff_data[2:0]};
   assign w_range_err = bus.i_coeff_data > (r_w4 ? 4'd8 : 4'd4);
   assign w_ovf       = ({1'b0, w_cnt_sh} + {1'b0, w_fw}) > c_CAP;
   assign w_append    = w_accept && !w_ovf;
   assign w_ins       = {{(c_ACC_W-4){1'b0}}, w_field} << w_cnt_sh;
   assign w_err_set   = (w_accept && (w_range_err || w_ovf)) ||
                        (bus.i_coeff_valid && (r_state == c_FLUSH));

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE, c_DONE: begin
            if (i_start) w_state_nxt = c_RUN;
         end
         c_RUN: begin
            if (w_accept && (r_cnt == c_LAST)) w_state_nxt = c_FLUSH;
         end
         c_FLUSH: begin
            // A word accepted this cycle counts as drained.
            if ((r_acc_cnt == 7'd0) && w_out_free) w_state_nxt = c_DONE;
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // ---------------- state outputs ----------------
   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         c_RUN, c_FLUSH: o_busy = 1'b1;
         c_DONE:         o_done = 1'b1;
         default:        ;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_w4        <= 1'b0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_acc_cnt   <= 7'd0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_start) begin
            r_w4      <= (i_security_level == 3'd3);
            r_cnt     <= '0;
            r_acc     <= '0;
            r_acc_cnt <= 7'd0;
            r_err     <= 1'b0;
         end else begin
            r_acc     <= w_acc_sh | (w_append ? w_ins : '0);
            r_acc_cnt <= w_cnt_sh + (w_append ? w_fw : 7'd0);
            if (w_accept)  r_cnt <= r_cnt + 1'b1;
            if (w_err_set) r_err <= 1'b1;
         end

         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_acc[WORD_W-1:0];
         end else if (r_out_valid && bus.i_word_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.o_word_valid = r_out_valid;
   assign bus.o_word_data  = r_out_data;
   assign o_err            = r_err;
endmodule
`default_nettype wire

// File: tb/tb_poly_s_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_s_pack
// Purpose  : Self-checking bench for poly_s_pack. Expected words are pushed to
//            a scoreboard queue when a polynomial is prepared and popped when
//            the DUT hands a word over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_s_pack;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_start = 1'b0;
   logic [2:0] i_security_level = 3'd2;
   logic       o_busy, o_done, o_err;

   poly_s_pack_if #(.WORD_W(32)) bus ();

   poly_s_pack #(.COEFF_NUM(256), .WORD_W(32)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .i_start          (i_start),
      .i_security_level (i_security_level),
      .bus              (bus.slave),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_err            (o_err)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];
   logic [3:0]  co[256];
   logic        prev_hold = 1'b0;
   logic [31:0] prev_data = '0;
   logic [31:0] exp_w;

   // Word monitor: pops the scoreboard on every handshake and checks that a
   // stalled word stays put.
   always @(negedge clk) begin
      if (prev_hold) begin
         checks++;
         assert (bus.o_word_valid === 1'b1 && bus.o_word_data === prev_data) else begin
            errors++;
            $error("FAIL hold: valid=%0b data=%h required valid=1 data=%h",
                   bus.o_word_valid, bus.o_word_data, prev_data);
         end
      end
      if (bus.o_word_valid === 1'b1 && bus.i_word_ready === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $error("FAIL word: unexpected word %h, scoreboard empty", bus.o_word_data);
         end else begin
            exp_w = sb.pop_front();
            assert (bus.o_word_data === exp_w) else begin
               errors++;
               $error("FAIL word: got %h required %h", bus.o_word_data, exp_w);
            end
         end
      end
      prev_hold = (bus.o_word_valid === 1'b1) && !bus.i_word_ready && !rst;
      prev_data = bus.o_word_data;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [2:0] lvl);
      i_security_level = lvl;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
   endtask

   task automatic drive(input logic [3:0] d);
      bus.i_coeff_valid = 1'b1;
      bus.i_coeff_data  = d;
      step();
      bus.i_coeff_valid = 1'b0;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0b required %0b", tag, obs, exp);
      end
   endtask

   // Reference BitPack: coefficient i at bits [i*w +: w], word k = bits [32k +: 32].
   task automatic push_model(input int w);
      logic [1023:0] p;
      p = '0;
      for (int i = 0; i < 256; i++)
         for (int b = 0; b < w; b++)
            p[i*w + b] = co[i][b];
      for (int k = 0; k < 8*w; k++)
         sb.push_back(p[32*k +: 32]);
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 3000 && o_done !== 1'b1; k++) step();
      check1(tag, o_done, 1'b1);
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL %s_drain: %0d words outstanding required 0", tag, sb.size());
      end
   endtask

   initial begin
      bus.i_coeff_valid = 1'b0;
      bus.i_coeff_data  = 4'd0;
      bus.i_word_ready  = 1'b0;
      step(); step();
      rst = 1'b0;

      // ---- reset state ----
      check1("rst_valid", bus.o_word_valid, 1'b0);
      check1("rst_busy",  o_busy, 1'b0);
      check1("rst_done",  o_done, 1'b0);
      check1("rst_err",   o_err,  1'b0);
      checks++;
      assert (bus.o_word_data === 32'h0) else begin
         errors++;
         $error("FAIL rst_data: got %h required 0", bus.o_word_data);
      end

      // ---- level 3, 1..8 repeated, ready high ----
      for (int k = 0; k < 32; k++) sb.push_back(32'h87654321);
      bus.i_word_ready = 1'b1;
      start(3'd3);
      check1("busy_after_start", o_busy, 1'b1);
      for (int i = 0; i < 256; i++) drive(4'((i % 8) + 1));
      wait_done("l3_done");
      check1("l3_err", o_err, 1'b0);

      // ---- level 2, all 4 ----
      for (int k = 0; k < 8; k++) begin
         sb.push_back(32'h24924924);
         sb.push_back(32'h49249249);
         sb.push_back(32'h92492492);
      end
      start(3'd2);
      for (int i = 0; i < 256; i++) drive(4'd4);
      wait_done("l2_done");
      check1("l2_err", o_err, 1'b0);
      drive(4'd4);                       // valid in DONE: ignored, no error
      check1("done_valid_err", o_err, 1'b0);
      check1("done_held", o_done, 1'b1);

      // ---- level 5, random rate and ready; start/level changes mid-run ignored ----
      for (int i = 0; i < 256; i++) co[i] = 4'($urandom_range(0, 4));
      push_model(3);
      start(3'd5);
      i_security_level = 3'd3;
      for (int i = 0; i < 256; ) begin
         bus.i_word_ready = 1'($urandom_range(0, 1));
         i_start = (i == 100);
         if ($urandom_range(0, 2) != 0) begin
            bus.i_coeff_valid = 1'b1;
            bus.i_coeff_data  = co[i];
            i++;
         end else begin
            bus.i_coeff_valid = 1'b0;
         end
         step();
      end
      bus.i_coeff_valid = 1'b0;
      i_start = 1'b0;
      bus.i_word_ready = 1'b1;
      wait_done("l5_done");
      check1("l5_err", o_err, 1'b0);

      // ---- level 3, ready low, 24 coefficients absorbed ----
      bus.i_word_ready = 1'b0;
      for (int i = 0; i < 256; i++) co[i] = 4'($urandom_range(0, 8));
      push_model(4);
      start(3'd3);
      for (int i = 0; i < 24; i++) drive(co[i]);
      step(); step();
      check1("cap24_err", o_err, 1'b0);
      check1("cap24_valid", bus.o_word_valid, 1'b1);
      bus.i_word_ready = 1'b1;
      for (int i = 24; i < 256; i++) drive(co[i]);
      wait_done("cap24_done");
      check1("cap24_err_end", o_err, 1'b0);

      // ---- level 3, ready low, 25th coefficient overflows; then reset ----
      bus.i_word_ready = 1'b0;
      start(3'd3);
      for (int i = 0; i < 24; i++) drive(4'd1);
      check1("ovf_pre", o_err, 1'b0);
      drive(4'd1);
      check1("ovf_25", o_err, 1'b1);
      for (int i = 25; i < 100; i++) drive(4'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check1("mid_rst_valid", bus.o_word_valid, 1'b0);
      check1("mid_rst_err",   o_err, 1'b0);
      check1("mid_rst_busy",  o_busy, 1'b0);

      // ---- fresh level 3 after reset ----
      bus.i_word_ready = 1'b1;
      for (int i = 0; i < 256; i++) co[i] = 4'($urandom_range(0, 8));
      push_model(4);
      start(3'd3);
      for (int i = 0; i < 256; i++) drive(co[i]);
      wait_done("post_rst_done");
      check1("post_rst_err", o_err, 1'b0);

      // ---- level 2, out-of-range value 6 at index 0 ----
      for (int i = 0; i < 256; i++) co[i] = 4'($urandom_range(0, 4));
      co[0] = 4'd6;
      push_model(3);
      start(3'd2);
      for (int i = 0; i < 256; i++) drive(co[i]);
      check1("range_err", o_err, 1'b1);
      wait_done("range_done");

      // ---- valid during FLUSH flags an error ----
      for (int i = 0; i < 256; i++) co[i] = 4'd0;
      push_model(3);
      start(3'd2);
      for (int i = 0; i < 256; i++) drive(4'd0);
      check1("flush_pre", o_err, 1'b0);
      drive(4'd0);
      check1("flush_err", o_err, 1'b1);
      wait_done("flush_done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
